// File: rtl/gpu_pkg.sv
// Shared definitions for the line-queue sequencer: register maps, command layout and FSM encoding.
package gpu_pkg;

    localparam int COORD_W = 9;
    localparam int CMD_W   = 4 * COORD_W + 1;

    typedef struct packed {
        logic [COORD_W-1:0] x0;
        logic [COORD_W-1:0] y0;
        logic [COORD_W-1:0] x1;
        logic [COORD_W-1:0] y1;
        logic               color;
    } line_cmd_t;

    localparam logic [3:0] CPU_X0       = 4'd0;
    localparam logic [3:0] CPU_Y0       = 4'd1;
    localparam logic [3:0] CPU_X1       = 4'd2;
    localparam logic [3:0] CPU_Y1       = 4'd3;
    localparam logic [3:0] CPU_COLOR    = 4'd4;
    localparam logic [3:0] CPU_PUSH     = 4'd5;
    localparam logic [3:0] CPU_STATUS   = 4'd6;
    localparam logic [3:0] CPU_LEVEL    = 4'd7;
    localparam logic [3:0] CPU_DONE_CNT = 4'd8;

    localparam logic [3:0] RAST_X0     = 4'd0;
    localparam logic [3:0] RAST_Y0     = 4'd1;
    localparam logic [3:0] RAST_X1     = 4'd2;
    localparam logic [3:0] RAST_Y1     = 4'd3;
    localparam logic [3:0] RAST_COLOR  = 4'd4;
    localparam logic [3:0] RAST_START  = 4'd5;
    localparam logic [3:0] RAST_STATUS = 4'd6;

    typedef enum logic [3:0] {
        S_IDLE, S_POP, S_WR_X0, S_WR_Y0, S_WR_X1, S_WR_Y1, S_WR_COL,
        S_WR_GO, S_POLL_REQ, S_POLL_BUSY, S_DONE
    } seq_state_t;

    // Rasterizer register addressed by each bus-transfer state.
    function automatic logic [3:0] rast_idx(input seq_state_t s);
        case (s)
            S_WR_X0:     return RAST_X0;
            S_WR_Y0:     return RAST_Y0;
            S_WR_X1:     return RAST_X1;
            S_WR_Y1:     return RAST_Y1;
            S_WR_COL:    return RAST_COLOR;
            S_WR_GO:     return RAST_START;
            S_POLL_REQ:  return RAST_START;
            S_POLL_BUSY: return RAST_STATUS;
            default:     return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/gpu_cmd_fifo.sv
// Synchronous command FIFO with a combinational head; full/empty are judged on pre-pop state.
module gpu_cmd_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 37
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         din_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign level_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/gpu_line_queue.sv
// CPU-facing line command queue that replays each queued line into the rasterizer over a Wishbone master.
module gpu_line_queue
    import gpu_pkg::*;
#(
    parameter int          DEPTH     = 8,
    parameter logic [31:0] RAST_BASE = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic        wb_ack_o,
    output logic [31:0] wb_dat_o,
    output logic        m_cyc_o,
    output logic        m_stb_o,
    output logic        m_we_o,
    output logic [3:0]  m_sel_o,
    output logic [31:0] m_adr_o,
    output logic [31:0] m_dat_o,
    input  logic [31:0] m_dat_i,
    input  logic        m_ack_i,
    output logic        done_o
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic        wb_ack_q, wb_ack_d;
    logic [31:0] wb_dat_q, wb_dat_d;
    line_cmd_t   stage_q, stage_d, cmd_q, cmd_d, fifo_dout;
    logic        overflow_q, overflow_d, active_q, active_d, m_cyc_q, m_cyc_d;
    logic [15:0] done_cnt_q, done_cnt_d;
    seq_state_t  state_q, state_d;
    logic        fifo_full, fifo_empty, fifo_pop, cpu_acc, cpu_wr, cpu_push, is_wr_state;
    logic [LW-1:0] fifo_level;
    logic [3:0]  cpu_idx;
    logic        unused_ok;

    assign unused_ok = ^{wb_sel_i, wb_adr_i[31:4], wb_dat_i[31:9], m_dat_i[31:1]};
    assign cpu_acc  = wb_cyc_i && wb_stb_i && !wb_ack_q;
    assign cpu_idx  = wb_adr_i[3:0];
    assign cpu_wr   = cpu_acc && wb_we_i;
    assign cpu_push = cpu_wr && (cpu_idx == CPU_PUSH);

    gpu_cmd_fifo #(.DEPTH(DEPTH), .WIDTH(CMD_W)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (cpu_push),
        .din_i   (stage_q),
        .pop_i   (fifo_pop),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    always_comb begin
        stage_d    = stage_q;
        overflow_d = overflow_q;
        done_cnt_d = (state_q == S_DONE) ? done_cnt_q + 16'd1 : done_cnt_q;
        wb_ack_d   = cpu_acc;
        wb_dat_d   = 32'd0;
        if (cpu_wr) begin
            case (cpu_idx)
                CPU_X0:       stage_d.x0    = wb_dat_i[COORD_W-1:0];
                CPU_Y0:       stage_d.y0    = wb_dat_i[COORD_W-1:0];
                CPU_X1:       stage_d.x1    = wb_dat_i[COORD_W-1:0];
                CPU_Y1:       stage_d.y1    = wb_dat_i[COORD_W-1:0];
                CPU_COLOR:    stage_d.color = wb_dat_i[0];
                CPU_PUSH:     if (fifo_full) overflow_d = 1'b1;
                CPU_STATUS:   if (wb_dat_i[0]) overflow_d = 1'b0;
                CPU_DONE_CNT: done_cnt_d = 16'd0;
                default: ;
            endcase
        end else if (cpu_acc) begin
            case (cpu_idx)
                CPU_X0:       wb_dat_d = {23'd0, stage_q.x0};
                CPU_Y0:       wb_dat_d = {23'd0, stage_q.y0};
                CPU_X1:       wb_dat_d = {23'd0, stage_q.x1};
                CPU_Y1:       wb_dat_d = {23'd0, stage_q.y1};
                CPU_COLOR:    wb_dat_d = {31'd0, stage_q.color};
                CPU_STATUS:   wb_dat_d = {28'd0, overflow_q, active_q, fifo_full, fifo_empty};
                CPU_LEVEL:    wb_dat_d = {{(32-LW){1'b0}}, fifo_level};
                CPU_DONE_CNT: wb_dat_d = {16'd0, done_cnt_q};
                default:      wb_dat_d = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_ack_q   <= 1'b0;
            wb_dat_q   <= 32'd0;
            stage_q    <= '0;
            overflow_q <= 1'b0;
            done_cnt_q <= 16'd0;
            state_q    <= S_IDLE;
            cmd_q      <= '0;
            active_q   <= 1'b0;
            m_cyc_q    <= 1'b0;
        end else begin
            wb_ack_q   <= wb_ack_d;
            wb_dat_q   <= wb_dat_d;
            stage_q    <= stage_d;
            overflow_q <= overflow_d;
            done_cnt_q <= done_cnt_d;
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            active_q   <= active_d;
            m_cyc_q    <= m_cyc_d;
        end
    end

    // Each transfer state raises cyc for one transfer and drops it on the ack edge.
    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        active_d = active_q;
        m_cyc_d  = m_cyc_q;
        fifo_pop = 1'b0;
        case (state_q)
            S_IDLE: if (!fifo_empty) state_d = S_POP;
            S_POP: begin
                cmd_d    = fifo_dout;
                fifo_pop = 1'b1;
                active_d = 1'b1;
                state_d  = S_WR_X0;
            end
            S_DONE: begin
                state_d = S_IDLE;
                if (fifo_empty) active_d = 1'b0;
            end
            default: begin
                if (!m_cyc_q) begin
                    m_cyc_d = 1'b1;
                end else if (m_ack_i) begin
                    m_cyc_d = 1'b0;
                    case (state_q)
                        S_WR_X0:     state_d = S_WR_Y0;
                        S_WR_Y0:     state_d = S_WR_X1;
                        S_WR_X1:     state_d = S_WR_Y1;
                        S_WR_Y1:     state_d = S_WR_COL;
                        S_WR_COL:    state_d = S_WR_GO;
                        S_WR_GO:     state_d = S_POLL_REQ;
                        S_POLL_REQ:  state_d = m_dat_i[0] ? S_POLL_REQ : S_POLL_BUSY;
                        S_POLL_BUSY: state_d = m_dat_i[0] ? S_POLL_BUSY : S_DONE;
                        default:     state_d = S_IDLE;
                    endcase
                end
            end
        endcase
    end

    always_comb begin
        is_wr_state = (state_q inside {S_WR_X0, S_WR_Y0, S_WR_X1, S_WR_Y1, S_WR_COL, S_WR_GO});
        wb_ack_o = wb_ack_q;
        wb_dat_o = wb_dat_q;
        m_cyc_o  = m_cyc_q;
        m_stb_o  = m_cyc_q;
        m_we_o   = m_cyc_q && is_wr_state;
        m_sel_o  = m_cyc_q ? 4'b1111 : 4'b0000;
        m_adr_o  = m_cyc_q ? RAST_BASE + {28'd0, rast_idx(state_q)} : 32'd0;
        done_o   = (state_q == S_DONE);
        m_dat_o  = 32'd0;
        if (m_cyc_q) begin
            case (state_q)
                S_WR_X0:  m_dat_o = {23'd0, cmd_q.x0};
                S_WR_Y0:  m_dat_o = {23'd0, cmd_q.y0};
                S_WR_X1:  m_dat_o = {23'd0, cmd_q.x1};
                S_WR_Y1:  m_dat_o = {23'd0, cmd_q.y1};
                S_WR_COL: m_dat_o = {31'd0, cmd_q.color};
                S_WR_GO:  m_dat_o = 32'd1;
                default:  m_dat_o = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_gpu_line_queue.sv
// Scoreboard bench: expected rasterizer writes and CPU reads are queued at issue time and checked by monitors.
module tb_gpu_line_queue;
    localparam int          DEPTH = 8;
    localparam logic [31:0] BASE  = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wb_cyc_i = 0, wb_stb_i = 0, wb_we_i = 0;
    logic [3:0]  wb_sel_i = 4'hF;
    logic [31:0] wb_adr_i = 0, wb_dat_i = 0;
    logic        wb_ack_o;
    logic [31:0] wb_dat_o;
    logic        m_cyc_o, m_stb_o, m_we_o;
    logic [3:0]  m_sel_o;
    logic [31:0] m_adr_o, m_dat_o;
    logic [31:0] m_dat_i = 0;
    logic        m_ack_i = 0;
    logic        done_o;

    int checks = 0;
    int failures = 0;
    int done_seen = 0;

    typedef struct { logic [3:0] idx; logic [31:0] data; } mwr_t;
    mwr_t        exp_m[$];
    logic [31:0] exp_rd[$];
    string       exp_rd_name[$];

    // Rasterizer slave model
    int   wait_states = 0;
    int   ws_cnt = 0;
    int   busy_cnt = 0;
    logic start_req = 0, busy = 0, stall = 0;

    gpu_line_queue #(.DEPTH(DEPTH), .RAST_BASE(BASE)) dut (
        .clk(clk), .rst(rst),
        .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i), .wb_sel_i(wb_sel_i),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_ack_o(wb_ack_o), .wb_dat_o(wb_dat_o),
        .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o), .m_sel_o(m_sel_o),
        .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_dat_i(m_dat_i), .m_ack_i(m_ack_i),
        .done_o(done_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end else begin
            $display("ok   %s value=0x%08h", name, act);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_ack_i   <= 1'b0;
            ws_cnt    <= 0;
            start_req <= 1'b0;
            busy      <= 1'b0;
            busy_cnt  <= 0;
        end else begin
            if (m_cyc_o && m_stb_o && !m_ack_i) begin
                if (ws_cnt >= wait_states) begin
                    m_ack_i <= 1'b1;
                    ws_cnt  <= 0;
                    m_dat_i <= (m_adr_o[3:0] == 4'd5) ? {31'd0, start_req} :
                               (m_adr_o[3:0] == 4'd6) ? {31'd0, busy} : 32'd0;
                end else begin
                    ws_cnt <= ws_cnt + 1;
                end
            end else begin
                m_ack_i <= 1'b0;
                ws_cnt  <= 0;
            end
            if (m_cyc_o && m_ack_i && m_we_o && m_adr_o[3:0] == 4'd5 && m_dat_o[0]) begin
                start_req <= 1'b1;
            end else if (start_req) begin
                start_req <= 1'b0;
                busy      <= 1'b1;
                busy_cnt  <= 5;
            end else if (busy && !stall) begin
                if (busy_cnt <= 1) busy <= 1'b0;
                busy_cnt <= busy_cnt - 1;
            end
        end
    end

    // Master-side monitor: every completed write must match the head of the expected queue.
    always @(negedge clk) begin
        if (m_cyc_o && m_stb_o && m_ack_i && m_we_o) begin
            if (exp_m.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL m_write_unexpected actual adr=0x%08h dat=0x%08h required=none", m_adr_o, m_dat_o);
            end else begin
                mwr_t e;
                e = exp_m.pop_front();
                check("m_write_adr", m_adr_o, BASE + {28'd0, e.idx});
                check("m_write_dat", m_dat_o, e.data);
                check("m_write_sel", {28'd0, m_sel_o}, 32'hF);
            end
        end
        if (done_o) done_seen++;
    end

    // CPU-side monitor for read responses.
    always @(posedge clk) begin
        #1;
        if (wb_ack_o && !wb_we_i && wb_cyc_i) begin
            if (exp_rd.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL cpu_read_unexpected actual=0x%08h required=none", wb_dat_o);
            end else begin
                string n;
                n = exp_rd_name.pop_front();
                check(n, wb_dat_o, exp_rd.pop_front());
            end
        end
    end

    task automatic cpu_xfer(input bit we, input logic [3:0] idx, input logic [31:0] d);
        bit got;
        got = 0;
        @(negedge clk);
        wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = we; wb_adr_i = {28'd0, idx}; wb_dat_i = d;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (wb_ack_o) begin got = 1; break; end
        end
        if (!got) begin
            checks++; failures++;
            $display("FAIL cpu_ack_timeout actual=no_ack required=ack idx=%0d", idx);
        end
        @(negedge clk);
        wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
    endtask

    task automatic cpu_rd(input string name, input logic [3:0] idx, input logic [31:0] exp);
        exp_rd.push_back(exp);
        exp_rd_name.push_back(name);
        cpu_xfer(0, idx, 32'd0);
    endtask

    task automatic expect_line(input int x0, input int y0, input int x1, input int y1, input int c);
        exp_m.push_back('{4'd0, 32'(x0)});
        exp_m.push_back('{4'd1, 32'(y0)});
        exp_m.push_back('{4'd2, 32'(x1)});
        exp_m.push_back('{4'd3, 32'(y1)});
        exp_m.push_back('{4'd4, 32'(c)});
        exp_m.push_back('{4'd5, 32'd1});
    endtask

    task automatic stage_line(input int x0, input int y0, input int x1, input int y1, input int c);
        cpu_xfer(1, 4'd0, 32'(x0));
        cpu_xfer(1, 4'd1, 32'(y0));
        cpu_xfer(1, 4'd2, 32'(x1));
        cpu_xfer(1, 4'd3, 32'(y1));
        cpu_xfer(1, 4'd4, 32'(c));
    endtask

    task automatic push_line(input int x0, input int y0, input int x1, input int y1, input int c, input bit expect_run);
        stage_line(x0, y0, x1, y1, c);
        if (expect_run) expect_line(x0, y0, x1, y1, c);
        cpu_xfer(1, 4'd5, 32'd0);
    endtask

    task automatic wait_done(input string name, input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #2;
            if (done_seen >= target) break;
        end
        check(name, 32'(done_seen), 32'(target));
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base_done;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 0;
        @(posedge clk); #1;
        check("reset_outputs", {28'd0, wb_ack_o, m_cyc_o, done_o, m_we_o}, 32'd0);
        check("reset_wb_dat", wb_dat_o, 32'd0);
        cpu_rd("reset_status", 4'd6, 32'h1);
        cpu_rd("reset_level", 4'd7, 32'd0);
        cpu_rd("reset_done_cnt", 4'd8, 32'd0);

        // Basic single line
        push_line(10, 20, 30, 25, 1, 1);
        wait_done("basic_done", 1, 500);
        cpu_rd("basic_done_cnt", 4'd8, 32'd1);
        cpu_rd("basic_status", 4'd6, 32'h1);

        // Overflow with stalled rasterizer
        stall = 1;
        push_line(40, 41, 42, 43, 0, 1);
        idle(40);
        for (int i = 1; i <= DEPTH; i++) push_line(i, i + 16, i + 32, i + 64, i & 1, 1);
        push_line(500, 501, 502, 503, 1, 0);
        cpu_rd("ovf_level", 4'd7, 32'(DEPTH));
        cpu_rd("ovf_status", 4'd6, 32'hE);
        stall = 0;
        wait_done("ovf_drain", 1 + DEPTH + 1, 3000);
        cpu_rd("ovf_done_cnt", 4'd8, 32'(DEPTH + 2));
        cpu_rd("ovf_status_drained", 4'd6, 32'h9);
        cpu_xfer(1, 4'd6, 32'd1);
        cpu_rd("ovf_cleared", 4'd6, 32'h1);
        check("ovf_queue_empty", 32'(exp_m.size()), 32'd0);

        // Staging rewrite during a draw does not touch the latched command
        stall = 1;
        push_line(5, 6, 7, 8, 0, 1);
        idle(30);
        cpu_xfer(1, 4'd0, 32'd99);
        cpu_rd("latch_stage_x0", 4'd0, 32'd99);
        expect_line(99, 6, 7, 8, 0);
        cpu_xfer(1, 4'd5, 32'd0);
        stall = 0;
        wait_done("latch_done", DEPTH + 4, 1000);

        // Slave with 3 wait states
        wait_states = 3;
        push_line(1, 2, 3, 4, 1, 1);
        wait_done("ws_done", DEPTH + 5, 1000);
        wait_states = 0;
        idle(20);
        check("ws_no_extra", 32'(exp_m.size()), 32'd0);
        check("ws_done_stable", 32'(done_seen), 32'(DEPTH + 5));

        cpu_xfer(1, 4'd12, 32'hFFFF_FFFF);
        cpu_rd("idx12_read", 4'd12, 32'd0);
        cpu_rd("color_readback", 4'd4, 32'd1);

        // Reset in POLL_BUSY with 3 queued
        stall = 1;
        push_line(11, 12, 13, 14, 1, 1);
        for (int i = 0; i < 3; i++) push_line(100 + i, 1, 2, 3, 0, 0);
        begin
            bit seen;
            seen = 0;
            for (int i = 0; i < 400; i++) begin
                @(negedge clk);
                if (m_cyc_o && m_adr_o == BASE + 32'd6) begin seen = 1; break; end
            end
            check("rst_reached_poll_busy", {31'd0, seen}, 32'd1);
        end
        check("rst_pre_writes", 32'(exp_m.size()), 32'd0);
        base_done = done_seen;
        rst = 1;
        @(posedge clk); #1;
        check("rst_cyc_drop", {31'd0, m_cyc_o}, 32'd0);
        @(negedge clk) rst = 0;
        stall = 0;
        cpu_rd("rst_level", 4'd7, 32'd0);
        cpu_rd("rst_done_cnt", 4'd8, 32'd0);
        cpu_rd("rst_status", 4'd6, 32'h1);
        idle(60);
        check("rst_no_done", 32'(done_seen), 32'(base_done));

        check("final_m_queue", 32'(exp_m.size()), 32'd0);
        check("final_rd_queue", 32'(exp_rd.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
